// File: rtl/sw_input_pkg.sv
// Shared constants for the switch input peripheral: register offsets and bus widths.
package sw_input_pkg;

    localparam int unsigned RD_W  = 32;
    localparam int unsigned EVT_W = 16;

    localparam logic [3:0] SW_OFF     = 4'h0;
    localparam logic [3:0] CHG_OFF    = 4'h4;
    localparam logic [3:0] STATUS_OFF = 4'h8;
    localparam logic [3:0] MASK_OFF   = 4'hC;

    // Register index (word select) of a byte offset inside the window
    function automatic logic [1:0] reg_idx(input logic [3:0] off);
        return off[3:2];
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// One-bit debouncer: accepts a new level only after DB_SAMPLES equal samples taken on tick.
module sw_debounce
    import sw_input_pkg::*;
#(
    parameter int unsigned DB_SAMPLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic din,
    output logic dout
);

    // Previous DB_SAMPLES-1 samples; together with din they form the full history window
    logic [DB_SAMPLES-2:0] hist;
    logic [DB_SAMPLES-1:0] window;

    assign window = {hist, din};

    // Shift history on tick and update the accepted level when the window is uniform
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
            dout <= 1'b0;
        end else if (tick) begin
            hist <= window[DB_SAMPLES-2:0];
            if (&window) begin
                dout <= 1'b1;
            end else if (~|window) begin
                dout <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sw_input_ctrl.sv
// Switch bank input peripheral: sync, debounce, sticky change flags, event counter, bus reads.
// Optional macro SW_IRQ_EN adds the IRQ mask register and the change interrupt.
module sw_input_ctrl
    import sw_input_pkg::*;
#(
    parameter int unsigned SW_W       = 24,
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned DB_SAMPLES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SW_W-1:0] device_sw,
    input  logic            rd_en,
    input  logic            wr_en,
    input  logic [3:0]      addr,
    input  logic [31:0]     wr_data,
    output logic [31:0]     rd_data,
    output logic            rd_valid,
    output logic [SW_W-1:0] sw_stable,
    output logic            irq
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);

    logic [SW_W-1:0]  sync1;
    logic [SW_W-1:0]  sync2;
    logic [SW_W-1:0]  stable_q;
    logic [SW_W-1:0]  change;
    logic [SW_W-1:0]  chg;
    logic [SW_W-1:0]  chg_clr;
    logic [SW_W-1:0]  chg_next;
    logic [SW_W-1:0]  mask_val;
    logic [CNT_W-1:0] pre_cnt;
    logic             tick;
    logic [EVT_W-1:0] evt_cnt;
    logic [RD_W-1:0]  rd_mux;
    logic             rd_chg;
    logic             rd_status;
    logic             unused_bits;

    assign unused_bits = ^{addr[1:0], wr_data, wr_en};

    // Two-flop synchroniser for the asynchronous switch levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= device_sw;
            sync2 <= sync1;
        end
    end

    // Debounce sample prescaler, tick on the last count before wrap
    assign tick = (pre_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + CNT_W'(1);
        end
    end

    // One debouncer per switch bit
    for (genvar i = 0; i < SW_W; i++) begin : g_db
        sw_debounce #(
            .DB_SAMPLES(DB_SAMPLES)
        ) u_db (
            .clk  (clk),
            .rst_n(rst_n),
            .tick (tick),
            .din  (sync2[i]),
            .dout (sw_stable[i])
        );
    end

    // Previous stable level for change detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= '0;
        end else begin
            stable_q <= sw_stable;
        end
    end

    assign change    = sw_stable ^ stable_q;
    assign rd_chg    = rd_en && (addr[3:2] == reg_idx(CHG_OFF));
    assign rd_status = rd_en && (addr[3:2] == reg_idx(STATUS_OFF));

    // A CHG read clears only the bits it returned; a concurrent change always sets
    assign chg_clr  = rd_chg ? chg : '0;
    assign chg_next = (chg & ~chg_clr) | change;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg <= '0;
        end else begin
            chg <= chg_next;
        end
    end

    // Saturating change-event counter, cleared by a STATUS read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_cnt <= '0;
        end else if (rd_status) begin
            evt_cnt <= (|change) ? EVT_W'(1) : '0;
        end else if ((|change) && (evt_cnt != '1)) begin
            evt_cnt <= evt_cnt + EVT_W'(1);
        end
    end

`ifdef SW_IRQ_EN
    logic [SW_W-1:0] mask;

    // Interrupt mask register and registered change interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= '0;
            irq  <= 1'b0;
        end else begin
            if (wr_en && (addr[3:2] == reg_idx(MASK_OFF))) begin
                mask <= wr_data[SW_W-1:0];
            end
            irq <= |(chg & mask);
        end
    end

    assign mask_val = mask;
`else
    assign mask_val = '0;
    assign irq      = 1'b0;
`endif

    // Read data selection by register index
    always_comb begin
        rd_mux = '0;
        case (addr[3:2])
            reg_idx(SW_OFF):     rd_mux = RD_W'(sw_stable);
            reg_idx(CHG_OFF):    rd_mux = RD_W'(chg);
            reg_idx(STATUS_OFF): rd_mux = {evt_cnt, 15'b0, |chg};
            reg_idx(MASK_OFF):   rd_mux = RD_W'(mask_val);
            default:             rd_mux = '0;
        endcase
    end

    // Registered read response, one cycle after the strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_sw_input_ctrl.sv
// Scoreboard bench for sw_input_ctrl (TICK_DIV=4, DB_SAMPLES=4); honours SW_IRQ_EN.
module tb_sw_input_ctrl;

    localparam int unsigned SW_W = 24;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [SW_W-1:0] device_sw = '0;
    logic            rd_en = 1'b0;
    logic            wr_en = 1'b0;
    logic [3:0]      addr = 4'h0;
    logic [31:0]     wr_data = '0;
    logic [31:0]     rd_data;
    logic            rd_valid;
    logic [SW_W-1:0] sw_stable;
    logic            irq;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    sw_input_ctrl #(
        .SW_W      (SW_W),
        .TICK_DIV  (4),
        .DB_SAMPLES(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .device_sw(device_sw),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .addr     (addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .sw_stable(sw_stable),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per rd_valid and checks data and latency
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rd_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rd_valid: got rd_data %h expected no response", rd_data);
                end else begin
                    e = sb.pop_front();
                    chk(e.name, rd_data, e.data);
                    chk({e.name, "_latency"}, 32'(cyc), 32'(e.cyc + 1));
                end
            end
        end
    end

    // All stimulus tasks are entered and left on a negedge
    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string name);
        exp_t e;
        rd_en = 1'b1;
        wr_en = 1'b0;
        addr  = a;
        e.data = exp;
        e.cyc  = cyc;
        e.name = name;
        sb.push_back(e);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        rd_en   = 1'b0;
        wr_en   = 1'b1;
        addr    = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rdwr(input logic [3:0] a, input logic [31:0] d, input logic [31:0] exp, input string name);
        exp_t e;
        rd_en   = 1'b1;
        wr_en   = 1'b1;
        addr    = a;
        wr_data = d;
        e.data = exp;
        e.cyc  = cyc;
        e.name = name;
        sb.push_back(e);
        @(negedge clk);
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic wait_stable(input int b, input logic v, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sw_stable[b] == v) begin
                found = 1'b1;
                break;
            end
        end
        chk(name, 32'(found), 32'd1);
    endtask

    initial begin
        bit stayed;

        // 1. reset values and first reads
        repeat (3) @(negedge clk);
        chk("reset_rd_data", rd_data, 32'h0);
        chk("reset_rd_valid", 32'(rd_valid), 32'h0);
        chk("reset_sw_stable", 32'(sw_stable), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        rd(4'h0, 32'h0, "t1_sw");
        rd(4'h4, 32'h0, "t1_chg");
        rd(4'h8, 32'h0, "t1_status");
        @(negedge clk);

        // 2. hold bit 0 high
        device_sw[0] = 1'b1;
        repeat (20) @(negedge clk);
        chk("t2_stable0", 32'(sw_stable), 32'h1);
        rd(4'h8, 32'h0001_0001, "t2_status");
        rd(4'h4, 32'h0000_0001, "t2_chg");
        rd(4'h0, 32'h0000_0001, "t2_sw");
        rd(4'h8, 32'h0000_0000, "t2_status_cleared");

        // 3. bouncing bit 3 never accepted
        stayed = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) device_sw[3] = ~device_sw[3];
            @(negedge clk);
            if (sw_stable[3] !== 1'b0) stayed = 1'b0;
        end
        device_sw[3] = 1'b0;
        chk("t3_no_accept", 32'(stayed), 32'd1);
        repeat (24) @(negedge clk);
        chk("t3_stable", 32'(sw_stable), 32'h1);
        rd(4'h4, 32'h0, "t3_chg");

        // 4. bit 5 edge coincides with a CHG read
        device_sw[5] = 1'b1;
        wait_stable(5, 1'b1, "t4_wait_bit5");
        rd(4'h4, 32'h0, "t4_chg_same_cycle");
        rd(4'h4, 32'h20, "t4_chg_next");

        // 5. interrupt mask and irq
        wr(4'hC, 32'h2);
`ifdef SW_IRQ_EN
        rd(4'hC, 32'h2, "t5_mask");
`else
        rd(4'hC, 32'h0, "t5_mask");
`endif
        device_sw[1] = 1'b1;
        wait_stable(1, 1'b1, "t5_wait_bit1");
        repeat (3) @(negedge clk);
`ifdef SW_IRQ_EN
        chk("t5_irq_set", 32'(irq), 32'h1);
`else
        chk("t5_irq_set", 32'(irq), 32'h0);
`endif
        rd(4'h4, 32'h2, "t5_chg");
        @(negedge clk);
        chk("t5_irq_clear", 32'(irq), 32'h0);
        device_sw[0] = 1'b0;
        wait_stable(0, 1'b0, "t5_wait_bit0");
        repeat (3) @(negedge clk);
        chk("t5_irq_unmasked", 32'(irq), 32'h0);
        rd(4'h4, 32'h1, "t5_chg_bit0");

        // read and write in the same cycle, width limit, ignored writes
`ifdef SW_IRQ_EN
        rdwr(4'hC, 32'hFFFF_FFFF, 32'h2, "rw_pre_write");
        rd(4'hC, 32'h00FF_FFFF, "rw_post_write");
`else
        rdwr(4'hC, 32'hFFFF_FFFF, 32'h0, "rw_pre_write");
        rd(4'hC, 32'h0, "rw_post_write");
`endif
        wr(4'h0, 32'hFFFF_FFFF);
        wr(4'h4, 32'hFFFF_FFFF);
        rd(4'h4, 32'h0, "ignored_chg_write");
        rd(4'h0, 32'h22, "ignored_sw_write");
        repeat (2) @(negedge clk);
        chk("drain_before_reset", 32'(sb.size()), 32'h0);

        // 6. reset while a read is in flight
        rd_en = 1'b1;
        addr  = 4'h8;
        #2 rst_n = 1'b0;
        @(negedge clk);
        rd_en = 1'b0;
        chk("t6_rd_valid", 32'(rd_valid), 32'h0);
        chk("t6_rd_data", rd_data, 32'h0);
        chk("t6_sw_stable", 32'(sw_stable), 32'h0);
        chk("t6_irq", 32'(irq), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_no_valid", 32'(rd_valid), 32'h0);
        rd(4'h8, 32'h0, "t6_status");

        // drain scoreboard
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_final", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
